hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 14 +
 rtl/hazard_unit_sat_counter.sv | 31 +++
 rtl/hazard_unit.sv | 127 ++++++++++++
 tb/tb_hazard_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: FSM state encoding and parameter defaults.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } hz_state_e;

  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_CNT_W        = 16;
  localparam int FCNT_W           = 3;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use bubbles, branch flush windows and memory freezes.
// Outputs are Mealy (same-cycle response); counters tally bubbles and taken branches.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [4:0]       exRt,
  input  logic             branchTaken,
  input  logic             memBusy,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             hazard,
  output logic             branchDet,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  hz_state_e         state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              load_use;
  logic              br_count;

  assign load_use = exMemRead && (exRt != 5'd0) &&
                    ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    pcWrite   = 1'b1;
    ifidWrite = 1'b1;
    hazard    = 1'b0;
    branchDet = 1'b0;
    br_count  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branchTaken) begin
          branchDet = 1'b1;
          br_count  = 1'b1;
          fcnt_d    = FLUSH_LOAD;
          state_d   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (memBusy) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          state_d   = FREEZE;
        end else if (load_use) begin
          hazard    = 1'b1;
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
        end
      end
      FLUSH: begin
        branchDet = 1'b1;
        if (branchTaken) begin
          br_count = 1'b1;
          fcnt_d   = FLUSH_LOAD;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
          if (fcnt_q == FCNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      FREEZE: begin
        // The branch stage is frozen here, so branchTaken is not trusted even on the exit cycle.
        if (memBusy) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
        end else begin
          state_d = RUN;
          if (load_use) begin
            hazard    = 1'b1;
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
          end
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    endcase

    if (rst) begin
      pcWrite   = 1'b1;
      ifidWrite = 1'b1;
      hazard    = 1'b0;
      branchDet = 1'b0;
      br_count  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (hazard),
    .cnt_o (stallCnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (br_count),
    .cnt_o (flushCnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (FLUSH_CYCLES=2, CNT_W=4); expectations queued, checked at negedge.
module tb_hazard_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    idRs = '0, idRt = '0, exRt = '0;
  logic          idUsesRt = 1'b0, exMemRead = 1'b0, branchTaken = 1'b0, memBusy = 1'b0;
  logic          pcWrite, ifidWrite, hazard, branchDet;
  logic [CW-1:0] stallCnt, flushCnt;

  int errors = 0;
  int checks = 0;

  logic [3+2*CW:0] exp_q[$];
  string           name_q[$];

  hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken), .memBusy(memBusy),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .hazard(hazard), .branchDet(branchDet),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3+2*CW:0] actual();
    return {pcWrite, ifidWrite, hazard, branchDet, stallCnt, flushCnt};
  endfunction

  task automatic compare(input string nm, input logic [3+2*CW:0] exp_v);
    logic [3+2*CW:0] act;
    act = actual();
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got pc/ifid/hz/bd=%b%b%b%b stall=%0d flush=%0d, want pc/ifid/hz/bd=%b%b%b%b stall=%0d flush=%0d",
               nm, act[3+2*CW], act[2+2*CW], act[1+2*CW], act[2*CW], act[2*CW-1:CW], act[CW-1:0],
               exp_v[3+2*CW], exp_v[2+2*CW], exp_v[1+2*CW], exp_v[2*CW], exp_v[2*CW-1:CW], exp_v[CW-1:0]);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one queued expectation is consumed per negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        compare(name_q.pop_front(), exp_q.pop_front());
      end
    end
  end

  task automatic drive_push(input string nm, input bit mr, input int xrt, input int rs, input int rt,
                            input bit ur, input bit br, input bit mb,
                            input bit pc, input bit ifd, input bit hz, input bit bd,
                            input int sc, input int fc);
    exMemRead   = mr;
    exRt        = 5'(xrt);
    idRs        = 5'(rs);
    idRt        = 5'(rt);
    idUsesRt    = ur;
    branchTaken = br;
    memBusy     = mb;
    exp_q.push_back({pc, ifd, hz, bd, CW'(sc), CW'(fc)});
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm, input bit mr, input int xrt, input int rs, input int rt,
                      input bit ur, input bit br, input bit mb,
                      input bit pc, input bit ifd, input bit hz, input bit bd,
                      input int sc, input int fc);
    drive_push(nm, mr, xrt, rs, rt, ur, br, mb, pc, ifd, hz, bd, sc, fc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    //    name              mr xrt rs rt ur br mb  pc if hz bd  sc fc
    step("reset_outputs",   1, 5,  5, 0, 0, 1, 1,  1, 1, 0, 0,  0, 0);
    rst = 1'b0;
    step("idle",            0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0);
    step("loaduse_rs",      1, 5,  5, 0, 0, 0, 0,  0, 0, 1, 0,  0, 0);
    step("after_bubble",    0, 0,  5, 0, 0, 0, 0,  1, 1, 0, 0,  1, 0);
    step("rt_zero",         1, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0,  1, 0);
    step("rt_unused",       1, 7,  0, 7, 0, 0, 0,  1, 1, 0, 0,  1, 0);
    step("loaduse_rt",      1, 7,  0, 7, 1, 0, 0,  0, 0, 1, 0,  1, 0);
    step("branch",          0, 0,  0, 0, 0, 1, 0,  1, 1, 0, 1,  2, 0);
    step("flush_loaduse",   1, 5,  5, 0, 0, 0, 0,  1, 1, 0, 1,  2, 1);
    step("flush_done",      0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0,  2, 1);
    step("branch_wins",     1, 5,  5, 0, 0, 1, 1,  1, 1, 0, 1,  2, 1);
    step("flush2",          0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 1,  2, 2);
    step("freeze1",         0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0,  2, 2);
    step("freeze2_br",      0, 0,  0, 0, 0, 1, 1,  0, 0, 0, 0,  2, 2);
    step("freeze3",         0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0,  2, 2);
    step("unfreeze",        0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0,  2, 2);
    step("post_freeze",     0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0,  2, 2);
    for (int i = 0; i < 20; i++) begin
      step("sat_loaduse",   1, 9,  9, 0, 0, 0, 0,  0, 0, 1, 0,  (2 + i > 15) ? 15 : 2 + i, 2);
    end
    step("sat_hold",        0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0,  15, 2);
    step("branch_pre_rst",  0, 0,  0, 0, 0, 1, 0,  1, 1, 0, 1,  15, 2);
    drive_push("flush_pre_rst", 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1,  15, 3);
    #6;
    rst = 1'b1;
    #1;
    compare("async_rst", {1'b1, 1'b1, 1'b0, 1'b0, CW'(0), CW'(0)});
    @(posedge clk);
    #1;
    step("rst_held_br",     1, 5,  5, 0, 0, 1, 1,  1, 1, 0, 0,  0, 0);
    rst = 1'b0;
    step("run_after_rst",   0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0);
    step("branch_after",    0, 0,  0, 0, 0, 1, 0,  1, 1, 0, 1,  0, 0);
    step("flush_after",     0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 1,  0, 1);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
